dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

- Data-memory access sequencer for the MEM stage of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM register outputs and drives a single-outstanding req/gnt/rvalid data-memory bus.
- Asserts `stall_mem` to freeze IF..MEM until the access completes.
- Returns aligned, sign- or zero-extended load data to the MEM/WB register.

## Interface

Parameters:
- `TIMEOUT`, 255: max cycles waiting in REQ or RESP before a bus error; 8-bit counter.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `memread_MEM` in 1: load in MEM.
- `memwrite_MEM` in 1: store in MEM. Never high together with `memread_MEM`.
- `load_unsigned_MEM` in 1: zero-extend (LBU/LHU). Otherwise sign-extend.
- `mask_MEM` in 4: access size. `0001` byte, `0011` half, `1111` word.
- `ALU_data_MEM` in 32: effective address.
- `store_data_MEM` in 32: store data, unshifted, LSB-aligned.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write.
- `dmem_addr` out 32: word address, `{ALU_data_MEM[31:2],2'b00}`.
- `dmem_be` out 4: byte enables, `mask_MEM << ALU_data_MEM[1:0]`.
- `dmem_wdata` out 32: `store_data_MEM << (8*ALU_data_MEM[1:0])`.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid. Earliest one cycle after `gnt`.
- `dmem_rdata` in 32: read word.
- `stall_mem` out 1: hold pipeline IF..MEM this cycle.
- `load_data_MEM` out 32: extended load result.
- `load_valid` out 1: `load_data_MEM` is valid this cycle.
- `misalign_exc` out 1: one-cycle pulse, misaligned access.
- `bus_err` out 1: one-cycle pulse, timeout.

## Operation

- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, no access: `stall_mem`=0.
- IDLE, aligned access: `dmem_req`=1 and `stall_mem`=1, both combinational, same cycle.
  - `gnt`=1 on a write → DONE.
  - `gnt`=1 on a read → RESP.
  - Else → REQ.
- IDLE, misaligned access (half with addr[0]=1, or word with addr[1:0]≠0):
  - No bus request.
  - `misalign_exc` pulses next cycle.
  - FSM goes to DONE with `load_data_MEM`=0.
- REQ: `dmem_req`=1 and `stall_mem`=1.
  - Bus outputs held stable, because the pipeline is frozen.
  - `gnt` → DONE (write) or RESP (read).
- RESP: `dmem_req`=0, `stall_mem`=1. On `rvalid`, capture `dmem_rdata` → DONE.
- DONE: `stall_mem`=0 and `load_valid`=`memread_MEM`. The pipeline advances at this edge. → IDLE.
  - DONE never issues. The instruction entering MEM at this edge is evaluated in IDLE next cycle.
- Timeout: the counter clears on entry to REQ/RESP and increments each cycle there. On reaching `TIMEOUT`:
  - `bus_err` pulses.
  - FSM goes to DONE with load data 0.
  - A late `rvalid`/`gnt` in IDLE is ignored.
- Load extraction: shift right by 8*addr[1:0]. Byte uses bits [7:0], half uses [15:0]. Extend per `load_unsigned_MEM`. Word passes through.
- Reset (any state, including mid-transaction):
  - FSM → IDLE, counter 0.
  - `dmem_req`=0, `stall_mem`=0.
  - `load_data_MEM`=0, `load_valid`=0, `misalign_exc`=0, `bus_err`=0.
  - Other bus outputs are don't-care while `dmem_req`=0.

## Timing

- Write, `gnt` in cycle T: `stall_mem` high in T only. DONE in T+1.
- Read, `gnt` in T, `rvalid` in T+k (k≥1): `stall_mem` high T..T+k. DONE with `load_valid` in T+k+1.
- `load_data_MEM` is registered and holds its value until the next load completes.
- Misaligned access: `stall_mem` high for one cycle. Pulse and DONE in the next cycle.
- Only one access is outstanding; `dmem_req` is never high in RESP or DONE.

## Structure

- Shared package `riscvx_pkg`:
  - Mask constants `MASK_B`, `MASK_H`, `MASK_W`.
  - FSM state enum `dmem_state_t`.
- Sub-module `load_align`: combinational rdata shift, select and extend. It is reused by the WB bypass path.
- All else lives in `dmem_ctrl`: FSM, timeout counter, bus output muxing.

## Test plan

- SW 0xDEADBEEF to 0x100, `gnt` immediate:
  - `dmem_be`=1111, `stall_mem` high 1 cycle.
  - Bus write of 0xDEADBEEF to 0x100.
- LB from 0x103, rdata 0x80000000, `gnt` delayed 2 cycles, `rvalid` 3 cycles after `gnt`:
  - `dmem_be`=1000, `stall_mem` 6 cycles.
  - `load_data_MEM`=0xFFFFFF80, `load_valid` 1 cycle.
- LHU from 0x102, rdata 0xBEEF1234 → `load_data_MEM`=0x0000BEEF.
- LW from 0x102:
  - No `dmem_req`.
  - `misalign_exc` single pulse, `stall_mem` 1 cycle.
- Read with `gnt`, no `rvalid`, `TIMEOUT`=4:
  - `bus_err` pulse after 4 RESP cycles, then IDLE.
  - Late `rvalid` is ignored.
- Reset driven low during RESP:
  - All outputs take reset values immediately.
  - After release, a new SB issues normally with `dmem_be` matching addr[1:0].

Source files
------------

// File: rtl/riscvx_pkg.sv
// Shared definitions for the RISC-V pipeline: access-size masks, the data-memory
// sequencer state encoding and the alignment rule for loads and stores.
package riscvx_pkg;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] offset);
        logic result;
        case (mask)
            MASK_H:  result = offset[0];
            MASK_W:  result = (offset != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Load data alignment: shifts the bus word down to the addressed byte lane and
// sign- or zero-extends it to 32 bits. Shared with the WB bypass path.
module load_align
    import riscvx_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  mask,
    input  logic        zext,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Lane select followed by size-dependent extension.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (mask)
            MASK_B:  data = {{24{~zext & shifted_s[7]}}, shifted_s[7:0]};
            MASK_H:  data = {{16{~zext & shifted_s[15]}}, shifted_s[15:0]};
            MASK_W:  data = shifted_s;
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/gnt/rvalid transaction per
// load/store, freezes the pipeline until it completes and returns load data.
module dmem_ctrl
    import riscvx_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_MEM,
    input  logic        memwrite_MEM,
    input  logic        load_unsigned_MEM,
    input  logic [3:0]  mask_MEM,
    input  logic [31:0] ALU_data_MEM,
    input  logic [31:0] store_data_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic [31:0] load_data_MEM,
    output logic        load_valid,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    dmem_state_t state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [31:0] load_data_r, load_data_nxt_s, aligned_s;
    logic        load_valid_r, load_valid_nxt_s;
    logic        misalign_r, misalign_nxt_s;
    logic        bus_err_r, bus_err_nxt_s;
    logic        access_s, misalign_s, req_s, stall_s;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (ALU_data_MEM[1:0]),
        .mask   (mask_MEM),
        .zext   (load_unsigned_MEM),
        .data   (aligned_s)
    );

    assign access_s   = memread_MEM | memwrite_MEM;
    assign misalign_s = is_misaligned(mask_MEM, ALU_data_MEM[1:0]);
    assign cnt_inc_s  = cnt_r + 8'd1;

    // Next-state, timeout counter and result capture.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        load_data_nxt_s = load_data_r;
        misalign_nxt_s  = 1'b0;
        bus_err_nxt_s   = 1'b0;
        req_s           = 1'b0;
        stall_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    stall_s = 1'b1;
                    if (misalign_s) begin
                        state_nxt_s     = DONE;
                        misalign_nxt_s  = 1'b1;
                        load_data_nxt_s = 32'h0000_0000;
                    end else begin
                        req_s     = 1'b1;
                        cnt_nxt_s = 8'd0;
                        if (dmem_gnt) begin
                            state_nxt_s = memwrite_MEM ? DONE : RESP;
                        end else begin
                            state_nxt_s = REQ;
                        end
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (dmem_gnt) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = memwrite_MEM ? DONE : RESP;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_nxt_s     = DONE;
                    bus_err_nxt_s   = 1'b1;
                    load_data_nxt_s = 32'h0000_0000;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            RESP: begin
                stall_s = 1'b1;
                if (dmem_rvalid) begin
                    state_nxt_s     = DONE;
                    load_data_nxt_s = aligned_s;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_nxt_s     = DONE;
                    bus_err_nxt_s   = 1'b1;
                    load_data_nxt_s = 32'h0000_0000;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // The instruction is frozen in MEM, so its memread is still valid in DONE.
        load_valid_nxt_s = (state_nxt_s == DONE) & memread_MEM;
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            load_data_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            load_data_r  <= load_data_nxt_s;
            load_valid_r <= load_valid_nxt_s;
            misalign_r   <= misalign_nxt_s;
            bus_err_r    <= bus_err_nxt_s;
        end
    end

    // Request and stall decode straight from the inputs in IDLE; masked while in reset.
    assign dmem_req      = req_s & reset;
    assign stall_mem     = stall_s & reset;
    assign dmem_we       = memwrite_MEM;
    assign dmem_addr     = {ALU_data_MEM[31:2], 2'b00};
    assign dmem_be       = mask_MEM << ALU_data_MEM[1:0];
    assign dmem_wdata    = store_data_MEM << {ALU_data_MEM[1:0], 3'b000};
    assign load_data_MEM = load_data_r;
    assign load_valid    = load_valid_r;
    assign misalign_exc  = misalign_r;
    assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus queues expected bus/load/exception
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_ctrl;
    import riscvx_pkg::*;

    localparam logic [1:0] K_BUS = 2'd0, K_MIS = 2'd1, K_BERR = 2'd2, K_LOAD = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread_MEM = 1'b0, memwrite_MEM = 1'b0, load_unsigned_MEM = 1'b0;
    logic [3:0]  mask_MEM = 4'b0000;
    logic [31:0] ALU_data_MEM = 32'h0, store_data_MEM = 32'h0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        stall_mem, load_valid, misalign_exc, bus_err;
    logic [31:0] load_data_MEM;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
        .load_unsigned_MEM(load_unsigned_MEM), .mask_MEM(mask_MEM),
        .ALU_data_MEM(ALU_data_MEM), .store_data_MEM(store_data_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .load_data_MEM(load_data_MEM),
        .load_valid(load_valid), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
        ev_t e;
        e = '{kind: kind, we: we, addr: addr, be: be, data: data};
        exp_q.push_back(e);
    endtask

    task automatic see(input logic [1:0] kind, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == K_BUS && kind == K_BUS) begin
                check("bus_we", 32'(we), 32'(e.we));
                check("bus_addr", addr, e.addr);
                check("bus_be", 32'(be), 32'(e.be));
                if (e.we) check("bus_wdata", data, e.data);
            end else if (e.kind == K_LOAD && kind == K_LOAD) begin
                check("load_data", data, e.data);
            end
        end
    endtask

    // Monitor: every presented output event is matched against the queue.
    always @(negedge clk) begin
        if (dmem_req && dmem_gnt) see(K_BUS, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        if (misalign_exc) see(K_MIS, 1'b0, 32'h0, 4'h0, 32'h0);
        if (bus_err) see(K_BERR, 1'b0, 32'h0, 4'h0, 32'h0);
        if (load_valid) see(K_LOAD, 1'b0, 32'h0, 4'h0, load_data_MEM);
    end

    // Drives one access with gnt at cycle gd and rvalid rvd cycles later (-1 = never).
    task automatic access(input string name, input logic rd, input logic wr, input logic uns,
                          input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] sdata,
                          input int gd, input int rvd, input logic [31:0] rdata, input int exp_stall);
        int nstall = 0;
        memread_MEM = rd; memwrite_MEM = wr; load_unsigned_MEM = uns;
        mask_MEM = mask; ALU_data_MEM = addr; store_data_MEM = sdata; dmem_rdata = rdata;
        for (int c = 0; c < 30; c++) begin
            dmem_gnt    = (gd >= 0) && (c == gd);
            dmem_rvalid = rd && (gd >= 0) && (rvd >= 0) && (c == gd + rvd);
            #3;
            if (!stall_mem) break;
            nstall++;
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check({name, "_stall_cycles"}, 32'(nstall), 32'(exp_stall));
        @(posedge clk); #1;
        memread_MEM = 1'b0; memwrite_MEM = 1'b0; load_unsigned_MEM = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(dmem_req), 32'h0);
        check({tag, "_stall"}, 32'(stall_mem), 32'h0);
        check({tag, "_load_data"}, load_data_MEM, 32'h0);
        check({tag, "_load_valid"}, 32'(load_valid), 32'h0);
        check({tag, "_misalign"}, 32'(misalign_exc), 32'h0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    endtask

    initial begin
        // Reset with a load presented: nothing may leak onto the bus.
        memread_MEM = 1'b1; mask_MEM = MASK_W; ALU_data_MEM = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        memread_MEM = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        push(K_BUS, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        access("sw", 1'b0, 1'b1, 1'b0, MASK_W, 32'h0000_0100, 32'hDEAD_BEEF, 0, -1, 32'h0, 1);

        push(K_BUS, 1'b0, 32'h0000_0100, 4'b1000, 32'h0);
        push(K_LOAD, 1'b0, 32'h0, 4'h0, 32'hFFFF_FF80);
        access("lb", 1'b1, 1'b0, 1'b0, MASK_B, 32'h0000_0103, 32'h0, 2, 3, 32'h8000_0000, 6);

        push(K_BUS, 1'b0, 32'h0000_0100, 4'b1100, 32'h0);
        push(K_LOAD, 1'b0, 32'h0, 4'h0, 32'h0000_BEEF);
        access("lhu", 1'b1, 1'b0, 1'b1, MASK_H, 32'h0000_0102, 32'h0, 0, 1, 32'hBEEF_1234, 2);

        @(posedge clk); #1;
        check("load_hold", load_data_MEM, 32'h0000_BEEF);
        check("load_valid_idle", 32'(load_valid), 32'h0);

        // Reset asserted while waiting for rvalid.
        push(K_BUS, 1'b0, 32'h0000_0200, 4'b1111, 32'h0);
        memread_MEM = 1'b1; mask_MEM = MASK_W; ALU_data_MEM = 32'h0000_0200; dmem_gnt = 1'b1;
        #3;
        check("rst_req_stall", 32'(stall_mem), 32'h1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #1;
        check("rst_resp_stall", 32'(stall_mem), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        memread_MEM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;

        push(K_BUS, 1'b1, 32'h0000_0300, 4'b0010, 32'h3456_A500);
        access("sb", 1'b0, 1'b1, 1'b0, MASK_B, 32'h0000_0301, 32'h1234_56A5, 0, -1, 32'h0, 1);

        push(K_BUS, 1'b0, 32'h0000_0100, 4'b0011, 32'h0);
        push(K_LOAD, 1'b0, 32'h0, 4'h0, 32'hFFFF_8001);
        access("lh", 1'b1, 1'b0, 1'b0, MASK_H, 32'h0000_0100, 32'h0, 1, 2, 32'h0000_8001, 4);

        // Timeout in RESP: four cycles without rvalid.
        push(K_BUS, 1'b0, 32'h0000_0400, 4'b1111, 32'h0);
        push(K_BERR, 1'b0, 32'h0, 4'h0, 32'h0);
        push(K_LOAD, 1'b0, 32'h0, 4'h0, 32'h0);
        access("lw_timeout", 1'b1, 1'b0, 1'b0, MASK_W, 32'h0000_0400, 32'h0, 0, -1, 32'h0, 5);

        // Late response arriving in IDLE is ignored.
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h1234_5678;
        #3;
        check("late_stall", 32'(stall_mem), 32'h0);
        check("late_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        #3;
        check("late_load_valid", 32'(load_valid), 32'h0);
        check("late_load_data", load_data_MEM, 32'h0);

        push(K_BUS, 1'b0, 32'h0000_0404, 4'b1111, 32'h0);
        push(K_LOAD, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D);
        @(posedge clk); #1;
        access("lw", 1'b1, 1'b0, 1'b0, MASK_W, 32'h0000_0404, 32'h0, 0, 1, 32'hCAFE_F00D, 2);

        // Misaligned word load: no request, one stall cycle, pulse plus zero data.
        push(K_MIS, 1'b0, 32'h0, 4'h0, 32'h0);
        push(K_LOAD, 1'b0, 32'h0, 4'h0, 32'h0);
        memread_MEM = 1'b1; mask_MEM = MASK_W; ALU_data_MEM = 32'h0000_0102;
        #3;
        check("mis_req", 32'(dmem_req), 32'h0);
        check("mis_stall", 32'(stall_mem), 32'h1);
        @(posedge clk); #1;
        #3;
        check("mis_done_stall", 32'(stall_mem), 32'h0);
        check("mis_done_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        memread_MEM = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
